// File: rtl/prod_unload_pkg.sv
// Shared constants and FSM state encoding for the product unloader.
package prod_unload_pkg;

  // Default output word width.
  localparam int WORD_W_DEF = 32;

  // Unloader FSM states. CSUM is reachable only in the checksum build.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } state_t;

endpackage : prod_unload_pkg

// File: rtl/product_unloader.sv
// product_unloader: captures one wide multiplier product and streams it out
// least-significant word first over a valid/ready handshake.
// Optional feature macro: PROD_UNLOAD_CSUM_EN appends one XOR checksum word
// after the data words and moves out_last onto that checksum word.
//
// state | meaning
// IDLE  | waiting for prod_vld; outputs quiet
// SEND  | presenting captured word[r_idx]; advance on out_vld && out_rdy
// CSUM  | presenting the XOR of all data words (checksum build only)
//
// 2*DATA_WIDTH must be an integer multiple of WORD_W.
module product_unloader
  import prod_unload_pkg::*;
#(
  parameter int DATA_WIDTH = 2048,
  parameter int WORD_W     = WORD_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*DATA_WIDTH-1:0] product,
  input  logic                    prod_vld,
  output logic [WORD_W-1:0]       out_dat,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic                    out_last,
  output logic                    busy,
  output logic                    drop
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int NWORDS = PROD_W / WORD_W;
  localparam int CNT_W  = $clog2(NWORDS + 1);
  localparam int SEL_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  state_t                         r_state;
  logic [NWORDS-1:0][WORD_W-1:0]  r_cap;
  logic [CNT_W-1:0]               r_idx;
  logic [WORD_W-1:0]              r_out_dat;
  logic                           r_out_vld;
  logic                           r_out_last;
  logic                           r_busy;
  logic                           r_drop;
`ifdef PROD_UNLOAD_CSUM_EN
  logic [WORD_W-1:0]              r_csum;
`endif

  logic                           w_accept;
  logic                           w_at_last;
  logic [CNT_W-1:0]               w_next_idx;
  logic [SEL_W-1:0]               w_next_sel;
  logic [WORD_W-1:0]              w_next_word;
  logic [WORD_W-1:0]              w_first_word;

  // Handshake and next-word select derived from the index of the word on the bus.
  always_comb begin
    w_accept     = r_out_vld & out_rdy;
    w_at_last    = (r_idx == LAST_IDX);
    w_next_idx   = r_idx + CNT_W'(1);
    w_next_sel   = w_next_idx[SEL_W-1:0];
    w_next_word  = r_cap[w_next_sel];
    w_first_word = product[WORD_W-1:0];
  end

  // Unloader FSM with registered outputs; the capture register only loads in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cap      <= '0;
      r_idx      <= '0;
      r_out_dat  <= '0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_busy     <= 1'b0;
      r_drop     <= 1'b0;
`ifdef PROD_UNLOAD_CSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      // Any prod_vld outside IDLE is discarded, including one coinciding with
      // acceptance of the final word, so frames are never back-to-back.
      r_drop <= prod_vld && (r_state != IDLE);

      case (r_state)
        IDLE: begin
          if (prod_vld) begin
            r_cap      <= product;
            r_idx      <= '0;
            r_out_dat  <= w_first_word;
            r_out_vld  <= 1'b1;
`ifdef PROD_UNLOAD_CSUM_EN
            r_out_last <= 1'b0;
            r_csum     <= '0;
`else
            r_out_last <= (NWORDS == 1);
`endif
            r_busy     <= 1'b1;
            r_state    <= SEND;
          end
        end

        SEND: begin
          if (w_accept) begin
`ifdef PROD_UNLOAD_CSUM_EN
            r_csum <= r_csum ^ r_out_dat;
`endif
            if (w_at_last) begin
`ifdef PROD_UNLOAD_CSUM_EN
              // Fold in the word being accepted now so the checksum is ready
              // on the very next cycle without a bubble.
              r_out_dat  <= r_csum ^ r_out_dat;
              r_out_last <= 1'b1;
              r_state    <= CSUM;
`else
              r_out_dat  <= '0;
              r_out_vld  <= 1'b0;
              r_out_last <= 1'b0;
              r_busy     <= 1'b0;
              r_state    <= IDLE;
`endif
            end else begin
              r_idx      <= w_next_idx;
              r_out_dat  <= w_next_word;
`ifdef PROD_UNLOAD_CSUM_EN
              r_out_last <= 1'b0;
`else
              r_out_last <= (w_next_idx == LAST_IDX);
`endif
            end
          end
        end

`ifdef PROD_UNLOAD_CSUM_EN
        CSUM: begin
          if (w_accept) begin
            r_idx      <= '0;
            r_out_dat  <= '0;
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
`endif

        default: begin
          r_idx      <= '0;
          r_out_dat  <= '0;
          r_out_vld  <= 1'b0;
          r_out_last <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign out_dat  = r_out_dat;
  assign out_vld  = r_out_vld;
  assign out_last = r_out_last;
  assign busy     = r_busy;
  assign drop     = r_drop;

endmodule : product_unloader

// File: tb/tb_product_unloader.sv
// Directed bench for product_unloader: a 64-bit-operand instance for the
// handshake/drop/reset cases and a default-size instance fed a true product.
module tb_product_unloader;

  localparam int NW = 4;
`ifdef PROD_UNLOAD_CSUM_EN
  localparam int FW  = NW + 1;
  localparam int BFW = 129;
`else
  localparam int FW  = NW;
  localparam int BFW = 128;
`endif

  logic         clk;
  logic         rst;
  logic [127:0] product;
  logic         prod_vld;
  logic [31:0]  out_dat;
  logic         out_vld;
  logic         out_rdy;
  logic         out_last;
  logic         busy;
  logic         drop;

  logic [4095:0] big_product;
  logic          big_pvld;
  logic [31:0]   big_dat;
  logic          big_vld;
  logic          big_rdy;
  logic          big_last;
  logic          big_busy;
  logic          big_drop;

  int total = 0;
  int bad   = 0;

  product_unloader #(.DATA_WIDTH(64), .WORD_W(32)) u_dut (
    .clk(clk), .rst(rst), .product(product), .prod_vld(prod_vld),
    .out_dat(out_dat), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_last(out_last), .busy(busy), .drop(drop)
  );

  product_unloader u_big (
    .clk(clk), .rst(rst), .product(big_product), .prod_vld(big_pvld),
    .out_dat(big_dat), .out_vld(big_vld), .out_rdy(big_rdy),
    .out_last(big_last), .busy(big_busy), .drop(big_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Handshake monitor, sampled on the falling edge ahead of the accepting edge.
  logic [31:0] w_q[$];
  bit          l_q[$];
  int          drop_cnt = 0;
  int          viol = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_dat;
  logic        prev_last;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && (!out_vld || out_dat !== prev_dat || out_last !== prev_last))
        viol++;
      if (out_vld && out_rdy) begin
        w_q.push_back(out_dat);
        l_q.push_back(out_last);
      end
      if (drop) drop_cnt++;
      prev_stall = out_vld && !out_rdy;
      prev_dat   = out_dat;
      prev_last  = out_last;
    end
  end

  logic [4095:0] big_got;
  logic [31:0]   big_cs_got;
  int            big_n = 0;
  int            big_last_n = 0;
  int            big_last_at = -1;

  always @(negedge clk) begin
    if (!rst && big_vld && big_rdy) begin
      if (big_n < 128) big_got[big_n*32 +: 32] = big_dat;
      else             big_cs_got = big_dat;
      if (big_last) begin
        big_last_n++;
        big_last_at = big_n;
      end
      big_n++;
    end
  end

  task automatic send_prod(input logic [127:0] p);
    product  = p;
    prod_vld = 1'b1;
    @(posedge clk); #1;
    prod_vld = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", 64'(n < 100), 64'd1);
  endtask

  task automatic clear_q();
    w_q.delete();
    l_q.delete();
  endtask

  // Frame check: data words LSW first, optional XOR word, out_last on final word only.
  task automatic check_frame(input string tag, input logic [127:0] p);
    logic [31:0] cs;
    logic [31:0] ew;
    cs = '0;
    for (int i = 0; i < NW; i++) cs = cs ^ p[i*32 +: 32];
    chk({tag, "_count"}, 64'(w_q.size()), 64'(FW));
    for (int i = 0; i < FW; i++) begin
      if (i < w_q.size()) begin
        ew = (i < NW) ? p[i*32 +: 32] : cs;
        chk($sformatf("%s_w%0d", tag, i), 64'(w_q[i]), 64'(ew));
        chk($sformatf("%s_last%0d", tag, i), 64'(l_q[i]), 64'(i == FW - 1));
      end
    end
  endtask

  localparam logic [127:0] P1 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] P2 = 128'h0000000C_0000000B_0000000A_AAAA5555;
  localparam logic [127:0] P3 = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;

  logic [6:0]    rdy_pat;
  int            n;
  logic [2047:0] ba;
  logic [2047:0] bb;
  logic [4095:0] bref;
  logic [31:0]   bcs;

  initial begin
    rst = 1'b1; product = '0; prod_vld = 1'b0; out_rdy = 1'b0;
    big_product = '0; big_pvld = 1'b0; big_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld",  64'(out_vld),  64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_dat",  64'(out_dat),  64'd0);
    chk("rst_busy", 64'(busy),     64'd0);
    chk("rst_drop", 64'(drop),     64'd0);
    chk("rst_big_vld", 64'(big_vld), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Straight frame, out_rdy held high.
    clear_q();
    out_rdy = 1'b1;
    send_prod(P1);
    chk("first_busy", 64'(busy),     64'd1);
    chk("first_vld",  64'(out_vld),  64'd1);
    chk("first_dat",  64'(out_dat),  64'h1);
    chk("first_last", 64'(out_last), 64'd0);
    wait_idle(n);
    chk("frame_cycles", 64'(n), 64'(FW));
    chk("end_vld", 64'(out_vld), 64'd0);
    check_frame("basic", P1);

    // Stalled frame with ready pattern 1,0,0,1,1,0,1.
    clear_q();
    viol = 0;
    rdy_pat = 7'b1011001;
    send_prod(P1);
    for (int i = 0; i < 7; i++) begin
      out_rdy = rdy_pat[i];
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    wait_idle(n);
    check_frame("stall", P1);
    chk("stall_stable", 64'(viol), 64'd0);

    // Second prod_vld two cycles into a frame is dropped; input bus changes too.
    clear_q();
    drop_cnt = 0;
    send_prod(P1);
    @(posedge clk); #1;
    product  = P3;
    prod_vld = 1'b1;
    @(posedge clk); #1;
    prod_vld = 1'b0;
    chk("drop_pulse", 64'(drop), 64'd1);
    @(posedge clk); #1;
    chk("drop_clear", 64'(drop), 64'd0);
    wait_idle(n);
    repeat (4) @(posedge clk);
    #1;
    chk("drop_count", 64'(drop_cnt), 64'd1);
    chk("drop_busy",  64'(busy),     64'd0);
    check_frame("drop", P1);

    // prod_vld coincident with acceptance of the final word.
    clear_q();
    drop_cnt = 0;
    send_prod(P2);
    repeat (FW - 1) @(posedge clk);
    #1;
    chk("b2b_last_up", 64'(out_last), 64'd1);
    product  = P1;
    prod_vld = 1'b1;
    @(posedge clk); #1;
    prod_vld = 1'b0;
    chk("b2b_drop", 64'(drop),    64'd1);
    chk("b2b_busy", 64'(busy),    64'd0);
    chk("b2b_vld",  64'(out_vld), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_drop_count", 64'(drop_cnt), 64'd1);
    check_frame("b2b", P2);

    // Reset mid-frame after two words, then a fresh frame.
    clear_q();
    send_prod(P1);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_words", 64'(w_q.size()), 64'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld",  64'(out_vld),  64'd0);
    chk("mid_rst_busy", 64'(busy),     64'd0);
    chk("mid_rst_dat",  64'(out_dat),  64'd0);
    chk("mid_rst_last", 64'(out_last), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_q();
    @(posedge clk); #1;
    chk("post_rst_idle", 64'(out_vld), 64'd0);
    send_prod(P2);
    wait_idle(n);
    check_frame("after_rst", P2);

    // Default-size instance fed a genuine 2048x2048 product, random ready.
    for (int i = 0; i < 64; i++) begin
      ba[i*32 +: 32] = $urandom();
      bb[i*32 +: 32] = $urandom();
    end
    bref = {2048'b0, ba} * {2048'b0, bb};
    bcs = '0;
    for (int i = 0; i < 128; i++) bcs = bcs ^ bref[i*32 +: 32];
    big_product = bref;
    big_pvld = 1'b1;
    @(posedge clk); #1;
    big_pvld = 1'b0;
    big_product = '0;
    n = 0;
    while (big_busy && n < 3000) begin
      big_rdy = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      n++;
    end
    big_rdy = 1'b0;
    chk("big_timeout", 64'(n < 3000), 64'd1);
    chk("big_count", 64'(big_n), 64'(BFW));
    chk("big_match", 64'(big_got == bref), 64'd1);
    chk("big_last_n", 64'(big_last_n), 64'd1);
    chk("big_last_at", 64'(big_last_at), 64'(BFW - 1));
`ifdef PROD_UNLOAD_CSUM_EN
    chk("big_csum", 64'(big_cs_got), 64'(bcs));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_product_unloader
